// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned SETS       = 64;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W      = $clog2(SETS);
    localparam int unsigned TAG_W      = ADDR_W - 3 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE
    } state_e;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[3+OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
        return a[3 +: OFF_W];
    endfunction

    // Byte address of word k within the line that holds a.
    function automatic logic [ADDR_W-1:0] line_word_addr(input logic [ADDR_W-1:0] a,
                                                         input logic [OFF_W-1:0]  k);
        return {a[ADDR_W-1:3+OFF_W], k, 3'b000};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data flop storage: one combinational read port, one write port,
// valid bits cleared asynchronously.
module dcache_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid_c,
    output logic [TAG_W-1:0]  rd_tag_c,
    output logic [DATA_W-1:0] rd_word_c,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic              wr_word_en,
    input  logic [DATA_W-1:0] wr_word,
    input  logic              wr_line_inv,
    input  logic              wr_line_set,
    input  logic [TAG_W-1:0]  wr_tag
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (wr_line_inv) begin
            valid_q[wr_idx] <= 1'b0;
        end else if (wr_line_set) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_line_set) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (wr_word_en) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
    end

    assign rd_valid_c = valid_q[rd_idx];
    assign rd_tag_c   = tag_q[rd_idx];
    assign rd_word_c  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// line refill over a single-word memory handshake.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dcache_en,
    input  logic              dcache_wren,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic [DATA_W-1:0] dcache_rdata,
    output logic              dcache_done,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              mreq_q, mreq_d;
    logic              mwren_q, mwren_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  mcnt_q, mcnt_d;

    logic              rd_valid_c;
    logic [TAG_W-1:0]  rd_tag_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              lookup_hit_c;
    logic              beat_ack_c;
    logic              arr_word_en_c, arr_inv_c, arr_set_c;
    logic [OFF_W-1:0]  arr_off_c;
    logic [DATA_W-1:0] arr_word_c;

    dcache_array u_array (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_idx      (idx_of(addr_q)),
        .rd_off      (off_of(addr_q)),
        .rd_valid_c  (rd_valid_c),
        .rd_tag_c    (rd_tag_c),
        .rd_word_c   (rd_word_c),
        .wr_idx      (idx_of(addr_q)),
        .wr_off      (arr_off_c),
        .wr_word_en  (arr_word_en_c),
        .wr_word     (arr_word_c),
        .wr_line_inv (arr_inv_c),
        .wr_line_set (arr_set_c),
        .wr_tag      (tag_of(addr_q))
    );

    assign lookup_hit_c = rd_valid_c && (rd_tag_c == tag_of(addr_q));
    assign beat_ack_c   = mreq_q && mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            beat_q   <= '0;
            cap_q    <= '0;
            hit_q    <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwren_q  <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            hcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            cap_q    <= cap_d;
            hit_q    <= hit_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            mreq_q   <= mreq_d;
            mwren_q  <= mwren_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            hcnt_q   <= hcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wren_d        = wren_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        beat_d        = beat_q;
        cap_d         = cap_q;
        hit_d         = hit_q;
        rdata_d       = '0;
        done_d        = 1'b0;
        mreq_d        = mreq_q;
        mwren_d       = mwren_q;
        maddr_d       = maddr_q;
        mwdata_d      = mwdata_q;
        hcnt_d        = hcnt_q;
        mcnt_d        = mcnt_q;
        arr_word_en_c = 1'b0;
        arr_inv_c     = 1'b0;
        arr_set_c     = 1'b0;
        arr_off_c     = beat_q;
        arr_word_c    = mem_rdata;

        case (state_q)
            S_IDLE: begin
                if (dcache_en) begin
                    wren_d  = dcache_wren;
                    addr_d  = dcache_addr & ~ADDR_W'(7);
                    wdata_d = dcache_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit_c;
                if (lookup_hit_c) begin
                    hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + CNT_W'(1);
                end else begin
                    mcnt_d = (mcnt_q == '1) ? mcnt_q : mcnt_q + CNT_W'(1);
                end
                if (wren_q) begin
                    mreq_d   = 1'b1;
                    mwren_d  = 1'b1;
                    maddr_d  = addr_q;
                    mwdata_d = wdata_q;
                    state_d  = S_WRITE;
                end else if (lookup_hit_c) begin
                    rdata_d = rd_word_c;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // Invalidate up front so an interrupted refill never leaves a hit.
                    arr_inv_c = 1'b1;
                    beat_d    = '0;
                    mreq_d    = 1'b1;
                    mwren_d   = 1'b0;
                    maddr_d   = line_word_addr(addr_q, '0);
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: begin
                if (beat_ack_c) begin
                    arr_word_en_c = 1'b1;
                    mreq_d        = 1'b0;
                    beat_d        = beat_q + OFF_W'(1);
                    if (beat_q == off_of(addr_q)) begin
                        cap_d = mem_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        arr_set_c = 1'b1;
                        done_d    = 1'b1;
                        rdata_d   = (beat_q == off_of(addr_q)) ? mem_rdata : cap_q;
                        state_d   = S_IDLE;
                    end
                end else if (!mreq_q) begin
                    mreq_d  = 1'b1;
                    maddr_d = line_word_addr(addr_q, beat_q);
                end
            end
            S_WRITE: begin
                if (beat_ack_c) begin
                    arr_word_en_c = hit_q;
                    arr_off_c     = off_of(addr_q);
                    arr_word_c    = wdata_q;
                    mreq_d        = 1'b0;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dcache_rdata = rdata_q;
    assign dcache_done  = done_q;
    assign mem_req      = mreq_q;
    assign mem_wren     = mwren_q;
    assign mem_addr     = maddr_q;
    assign mem_wdata    = mwdata_q;
    assign hit_count    = hcnt_q;
    assign miss_count   = mcnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus randomized traffic checked
// against a line-level cache model and a word-addressed memory model.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dcache_en = 1'b0;
    logic              dcache_wren = 1'b0;
    logic [ADDR_W-1:0] dcache_addr = '0;
    logic [DATA_W-1:0] dcache_wdata = '0;
    logic [DATA_W-1:0] dcache_rdata;
    logic              dcache_done;
    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dcache_en    (dcache_en),
        .dcache_wren  (dcache_wren),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_done  (dcache_done),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    typedef struct {
        bit          w;
        logic [63:0] a;
        logic [63:0] d;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [63:0] mem_m [logic [63:0]];
    bit          ref_valid [SETS];
    logic [63:0] ref_line  [SETS];
    int unsigned ref_hits;
    int unsigned ref_misses;
    int          checks = 0;
    int          passes = 0;
    int          delay = 0;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    // Memory responder: random ack latency, stray acks while idle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (reset_n && mem_req) begin
                if (delay == 0) begin
                    mem_ack = 1'b1;
                    if (mem_wren) begin
                        mem_m[mem_addr] = mem_wdata;
                        log_q.push_back('{1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                        log_q.push_back('{1'b0, mem_addr, mem_rdata});
                    end
                    delay = int'($urandom_range(0, 3));
                end else begin
                    delay--;
                end
            end else if (!mem_req && $urandom_range(0, 5) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Reference model: one line per set, a hit means same line address resident.
    task automatic ref_access(input bit w, input logic [63:0] addr, input logic [63:0] wd,
                              output bit hit, output logic [63:0] rd);
        logic [63:0] a    = addr & ~64'h7;
        logic [63:0] line = a / (LINE_WORDS * 8);
        int          set  = int'(line % SETS);
        exp_q.delete();
        hit = ref_valid[set] && (ref_line[set] == line);
        if (hit) ref_hits++; else ref_misses++;
        rd = '0;
        if (w) begin
            exp_q.push_back('{1'b1, a, wd});
        end else begin
            rd = mem_rd(a);
            if (!hit) begin
                for (int k = 0; k < LINE_WORDS; k++)
                    exp_q.push_back('{1'b0, line * (LINE_WORDS * 8) + 64'(8 * k),
                                      mem_rd(line * (LINE_WORDS * 8) + 64'(8 * k))});
                ref_valid[set] = 1'b1;
                ref_line[set]  = line;
            end
        end
    endtask

    task automatic ref_reset();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    function automatic bit logs_match();
        if (log_q.size() != exp_q.size()) return 1'b0;
        foreach (log_q[i])
            if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d)
                return 1'b0;
        return 1'b1;
    endfunction

    // Issue one request, toss ignored junk requests while busy, observe completion.
    task automatic access(input bit w, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output int cyc, output int ndone);
        log_q.delete();
        dcache_en    = 1'b1;
        dcache_wren  = w;
        dcache_addr  = a;
        dcache_wdata = wd;
        cyc = 0;
        ndone = 0;
        rd = '0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (dcache_done) begin
                ndone++;
                rd = dcache_rdata;
            end
            if (!dcache_done && $urandom_range(0, 3) == 0) begin
                dcache_en    = 1'b1;
                dcache_wren  = 1'($urandom);
                dcache_addr  = {$urandom, $urandom};
                dcache_wdata = {$urandom, $urandom};
            end else begin
                dcache_en = 1'b0;
            end
        end while (ndone == 0 && cyc < 400);
        dcache_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (dcache_done) ndone++;
        end
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        dcache_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ref_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dcache_done, dcache_rdata, mem_req, mem_wren, mem_addr, mem_wdata, hit_count, miss_count} !== '0)
            $display("FAIL reset_outputs: done=%0b req=%0b addr=%h hits=%0d misses=%0d expected all zero",
                     dcache_done, mem_req, mem_addr, hit_count, miss_count);
        else passes++;
    endtask

    task automatic test_refill();
        logic [63:0] rd, erd;
        int cyc, nd;
        bit hit;
        ref_access(1'b0, 64'h1000, '0, hit, erd);
        access(1'b0, 64'h1000, '0, rd, cyc, nd);
        checks++;
        if (nd !== 1) $display("FAIL refill_done: got %0d pulses, expected 1", nd); else passes++;
        checks++;
        if (rd !== mem_rd(64'h1000)) $display("FAIL refill_rdata: got %h expected %h", rd, mem_rd(64'h1000));
        else passes++;
        checks++;
        if (log_q.size() != 4 || log_q[0].a !== 64'h1000 || log_q[3].a !== 64'h1018 || !logs_match())
            $display("FAIL refill_beats: got %0d beats, expected 4 reads 0x1000..0x1018", log_q.size());
        else passes++;
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0)
            $display("FAIL refill_counts: hits=%0d misses=%0d expected 0/1", hit_count, miss_count);
        else passes++;
    endtask

    task automatic test_read_hit();
        logic [63:0] rd, erd;
        int cyc, nd;
        bit hit;
        ref_access(1'b0, 64'h1010, '0, hit, erd);
        access(1'b0, 64'h1010, '0, rd, cyc, nd);
        checks++;
        if (cyc !== 2 || nd !== 1) $display("FAIL hit_latency: done at cycle %0d (%0d pulses), expected cycle 2", cyc, nd);
        else passes++;
        checks++;
        if (rd !== mem_rd(64'h1010) || log_q.size() != 0)
            $display("FAIL hit_data: got %h with %0d mem ops, expected %h with none", rd, log_q.size(), mem_rd(64'h1010));
        else passes++;
        checks++;
        if (hit_count !== 32'd1) $display("FAIL hit_count: got %0d expected 1", hit_count); else passes++;
    endtask

    task automatic test_write_hit();
        logic [63:0] rd, erd;
        int cyc, nd;
        bit hit;
        ref_access(1'b1, 64'h1008, 64'hAA, hit, erd);
        access(1'b1, 64'h1008, 64'hAA, rd, cyc, nd);
        checks++;
        if (nd !== 1 || rd !== 64'h0 || log_q.size() != 1 || log_q[0].w !== 1'b1 ||
            log_q[0].a !== 64'h1008 || log_q[0].d !== 64'hAA)
            $display("FAIL wr_hit_mem: done=%0d rdata=%h ops=%0d, expected one write 0x1008/0xAA", nd, rd, log_q.size());
        else passes++;
        ref_access(1'b0, 64'h1008, '0, hit, erd);
        access(1'b0, 64'h1008, '0, rd, cyc, nd);
        checks++;
        if (rd !== 64'hAA || cyc !== 2 || log_q.size() != 0)
            $display("FAIL wr_hit_readback: got %h at cycle %0d with %0d ops, expected 0xaa at 2 with none",
                     rd, cyc, log_q.size());
        else passes++;
    endtask

    task automatic test_write_miss();
        logic [63:0] rd, erd;
        int cyc, nd;
        bit hit;
        ref_access(1'b1, 64'h8000, 64'h55, hit, erd);
        access(1'b1, 64'h8000, 64'h55, rd, cyc, nd);
        checks++;
        if (nd !== 1 || log_q.size() != 1 || log_q[0].a !== 64'h8000 || log_q[0].d !== 64'h55)
            $display("FAIL wr_miss_mem: done=%0d ops=%0d, expected one write 0x8000/0x55", nd, log_q.size());
        else passes++;
        ref_access(1'b0, 64'h8000, '0, hit, erd);
        access(1'b0, 64'h8000, '0, rd, cyc, nd);
        checks++;
        if (rd !== 64'h55 || log_q.size() != 4 || !logs_match())
            $display("FAIL no_write_alloc: got %h with %0d ops, expected 0x55 after a 4-beat refill", rd, log_q.size());
        else passes++;
    endtask

    task automatic test_conflict();
        logic [63:0] rd, erd;
        logic [63:0] seq [3];
        int cyc, nd;
        bit hit;
        seq[0] = 64'h1000;
        seq[1] = 64'h1000 + SETS * 32;
        seq[2] = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            ref_access(1'b0, seq[i], '0, hit, erd);
            access(1'b0, seq[i], '0, rd, cyc, nd);
            checks++;
            if ((i > 0 && hit) || rd !== erd || !logs_match() || (!hit && log_q.size() != 4))
                $display("FAIL conflict_%0d: addr=%h got %h with %0d ops, expected %h with a refill",
                         i, seq[i], rd, log_q.size(), erd);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [63:0] rd, erd;
        int cyc, nd, k;
        bit hit;
        ref_access(1'b0, 64'h2040, '0, hit, erd);
        log_q.delete();
        dcache_en   = 1'b1;
        dcache_wren = 1'b0;
        dcache_addr = 64'h2040;
        nd = 0;
        k  = 0;
        while (log_q.size() < 2 && k < 400) begin
            @(posedge clk);
            #1;
            dcache_en = 1'b1;
            dcache_addr = 64'h9000;
            if (dcache_done) nd++;
            k++;
        end
        @(posedge clk);
        #1;
        if (dcache_done) nd++;
        dcache_en = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (log_q.size() != 2 || nd != 0 ||
            {dcache_done, dcache_rdata, mem_req, mem_wren, mem_addr, mem_wdata, hit_count, miss_count} !== '0)
            $display("FAIL mid_reset: beats=%0d dones=%0d req=%0b addr=%h, expected 2 beats, no done, outputs zero",
                     log_q.size(), nd, mem_req, mem_addr);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ref_reset();
        ref_access(1'b0, 64'h2040, '0, hit, erd);
        access(1'b0, 64'h2040, '0, rd, cyc, nd);
        checks++;
        if (nd !== 1 || rd !== erd || log_q.size() != 4 || !logs_match() || miss_count !== 32'd1)
            $display("FAIL post_reset_refill: ops=%0d rdata=%h misses=%0d, expected 4 beats, %h, 1",
                     log_q.size(), rd, miss_count, erd);
        else passes++;
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, a, wd;
        int cyc, nd;
        bit hit, w;
        for (int n = 0; n < 200; n++) begin
            w  = ($urandom_range(0, 9) < 3);
            a  = (64'($urandom_range(0, 3)) << 11) | (64'($urandom_range(0, 3)) << 5) |
                 (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            ref_access(w, a, wd, hit, erd);
            access(w, a, wd, rd, cyc, nd);
            checks++;
            if (nd !== 1 || rd !== erd || !logs_match() || (!w && hit && cyc !== 2))
                $display("FAIL rand_%0d: %s addr=%h got %h done=%0d cyc=%0d ops=%0d expected %h ops=%0d",
                         n, w ? "wr" : "rd", a, rd, nd, cyc, log_q.size(), erd, exp_q.size());
            else passes++;
            checks++;
            if (hit_count !== ref_hits || miss_count !== ref_misses)
                $display("FAIL rand_counts_%0d: hits=%0d misses=%0d expected %0d/%0d",
                         n, hit_count, miss_count, ref_hits, ref_misses);
            else passes++;
        end
    endtask

    initial begin
        ref_reset();
        test_reset();
        test_refill();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
